// File: rtl/conv_ctrl_fsm_param.sv
// Parametrised conv accelerator sequencer: host word loads, per-pixel datapath strobes, output beats.
// Optional stall counter output enabled by defining CONV_CTRL_PERF_CNT_EN.
module conv_ctrl_fsm_param #(
  parameter int unsigned FEATURE_MAP_WIDTH  = 64,
  parameter int unsigned FEATURE_MAP_HEIGHT = 64,
  parameter int unsigned OUTPUT_NB_CHANNELS = 32,
  parameter int unsigned CH_OUT_PAR         = 6,
  parameter int unsigned ODS_LANES          = 3,
  parameter int unsigned KERNEL_SIZE        = 3,
  parameter int unsigned K_WORDS            = 12,
  parameter int unsigned I_WORDS            = 4
) (
  input  logic        clk,
  input  logic        arst_n_in,
  input  logic        start,
  output logic        running,
  output logic        done,
  input  logic        con_valid,
  output logic        con_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic [15:0] out_ch,
  output logic        ctrl_kds_le,
  output logic [7:0]  ctrl_kds_ch,
  output logic [7:0]  ctrl_kds_word,
  output logic        ctrl_kds_cycle_en,
  output logic [7:0]  ctrl_ids_le_sel,
  output logic        ctrl_ids_shift,
  output logic [1:0]  ctrl_ods_sel,
  output logic        ctrl_ods_shift,
`ifdef CONV_CTRL_PERF_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        driving_cons
);

  localparam int unsigned OutBeats = CH_OUT_PAR / ODS_LANES;

  typedef enum logic [2:0] {
    StIdle, StLoadK, StLoadI, StShiftI, StCompute, StWait, StOutput, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d, ch_base_q, ch_base_d;
  // word_q is reused as kernel word, input word, compute beat and output beat index
  logic [15:0] word_q, word_d, kch_q, kch_d, row_q, row_d;
  logic [15:0] beat_ch;
  logic        last_out, adv;

  assign beat_ch  = ch_base_q + word_q * 16'(ODS_LANES);
  // Beats past the channel count are never issued, so the group ends early
  assign last_out = (word_q == 16'(OutBeats - 1)) ||
                    (32'(beat_ch) + ODS_LANES >= OUTPUT_NB_CHANNELS);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      ch_base_q <= '0;
      word_q    <= '0;
      kch_q     <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ch_base_q <= ch_base_d;
      word_q    <= word_d;
      kch_q     <= kch_d;
      row_q     <= row_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    x_d               = x_q;
    y_d               = y_q;
    ch_base_d         = ch_base_q;
    word_d            = word_q;
    kch_d             = kch_q;
    row_d             = row_q;
    adv               = 1'b0;
    running           = (state_q != StIdle);
    done              = 1'b0;
    con_ready         = 1'b0;
    out_valid         = 1'b0;
    out_x             = '0;
    out_y             = '0;
    out_ch            = '0;
    ctrl_kds_le       = 1'b0;
    ctrl_kds_ch       = '0;
    ctrl_kds_word     = '0;
    ctrl_kds_cycle_en = 1'b0;
    ctrl_ids_le_sel   = '0;
    ctrl_ids_shift    = 1'b0;
    ctrl_ods_sel      = '0;
    ctrl_ods_shift    = 1'b0;
    driving_cons      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoadK;
          x_d       = '0;
          y_d       = '0;
          ch_base_d = '0;
          word_d    = '0;
          kch_d     = '0;
          row_d     = '0;
        end
      end
      StLoadK: begin
        con_ready = 1'b1;
        if (con_valid) begin
          ctrl_kds_le   = 1'b1;
          ctrl_kds_ch   = 8'(kch_q);
          ctrl_kds_word = 8'(word_q);
          if (word_q == 16'(K_WORDS - 1)) begin
            word_d = '0;
            if (kch_q == 16'(CH_OUT_PAR - 1)) begin
              kch_d   = '0;
              state_d = StLoadI;
            end else begin
              kch_d = kch_q + 16'd1;
            end
          end else begin
            word_d = word_q + 16'd1;
          end
        end
      end
      StLoadI: begin
        con_ready = 1'b1;
        if (con_valid) begin
          ctrl_ids_le_sel = 8'(word_q + 16'd1);
          if (word_q == 16'(I_WORDS - 1)) begin
            word_d  = '0;
            state_d = StShiftI;
          end else begin
            word_d = word_q + 16'd1;
          end
        end
      end
      StShiftI: begin
        ctrl_ids_shift = 1'b1;
        if (row_q == 16'(KERNEL_SIZE - 1)) begin
          row_d   = '0;
          state_d = StCompute;
        end else begin
          row_d   = row_q + 16'd1;
          state_d = StLoadI;
        end
      end
      StCompute: begin
        ctrl_ods_sel = 2'(word_q % 16'(KERNEL_SIZE));
        if (word_q < 16'(I_WORDS)) begin
          con_ready = 1'b1;
          adv       = con_valid;
        end else begin
          adv = 1'b1;
        end
        if (adv) begin
          ctrl_kds_cycle_en = 1'b1;
          if (word_q < 16'(I_WORDS)) ctrl_ids_le_sel = 8'(word_q + 16'd1);
          if (word_q == 16'd0 ||
              (word_q >= 16'(KERNEL_SIZE) && word_q <= 16'(2 * KERNEL_SIZE - 2))) begin
            ctrl_ods_shift = 1'b1;
          end
          if (word_q == 16'(2 * KERNEL_SIZE - 1)) begin
            ctrl_ids_shift = 1'b1;
            word_d         = '0;
            state_d        = StWait;
          end else begin
            word_d = word_q + 16'd1;
          end
        end
      end
      StWait: state_d = StOutput;
      StOutput: begin
        driving_cons = 1'b1;
        out_valid    = 1'b1;
        out_x        = x_q;
        out_y        = y_q;
        out_ch       = beat_ch;
        if (out_ready) begin
          ctrl_ods_shift = 1'b1;
          if (last_out) begin
            word_d = '0;
            if (x_q < 16'(FEATURE_MAP_WIDTH - 1)) begin
              x_d     = x_q + 16'd1;
              state_d = StCompute;
            end else begin
              x_d = '0;
              if (y_q < 16'(FEATURE_MAP_HEIGHT - 1)) begin
                y_d     = y_q + 16'd1;
                state_d = StLoadI;
              end else begin
                y_d = '0;
                if (32'(ch_base_q) + CH_OUT_PAR < OUTPUT_NB_CHANNELS) begin
                  ch_base_d = ch_base_q + 16'(CH_OUT_PAR);
                  state_d   = StLoadK;
                end else begin
                  state_d = StDone;
                end
              end
            end
          end else begin
            word_d = word_q + 16'd1;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef CONV_CTRL_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      stall_q <= '0;
    end else if (state_q == StIdle && start) begin
      stall_q <= '0;
    end else if (((out_valid && !out_ready) || (con_ready && !con_valid)) && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_ctrl_fsm_param.sv
// Bench: directed default-config sequence plus randomised small layers against a beat-order model.
module tb_conv_ctrl_fsm_param;

  localparam int BW = 3;
  localparam int BH = 2;
  localparam int BNB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default parameters
  logic a_rst_n, a_start, a_running, a_done, a_con_valid, a_con_ready, a_out_valid, a_out_ready;
  logic [15:0] a_out_x, a_out_y, a_out_ch;
  logic a_kds_le, a_kds_cycle_en, a_ids_shift, a_ods_shift, a_driving;
  logic [7:0] a_kds_ch, a_kds_word, a_ids_le_sel;
  logic [1:0] a_ods_sel;
  // Instance B: small layer, channel count not a multiple of the group size
  logic b_rst_n, b_start, b_running, b_done, b_con_valid, b_con_ready, b_out_valid, b_out_ready;
  logic [15:0] b_out_x, b_out_y, b_out_ch;
  logic b_kds_le, b_kds_cycle_en, b_ids_shift, b_ods_shift, b_driving;
  logic [7:0] b_kds_ch, b_kds_word, b_ids_le_sel;
  logic [1:0] b_ods_sel;
`ifdef CONV_CTRL_PERF_CNT_EN
  logic [31:0] a_stall, b_stall;
`endif

  conv_ctrl_fsm_param u_dut_a (
    .clk(clk), .arst_n_in(a_rst_n), .start(a_start), .running(a_running), .done(a_done),
    .con_valid(a_con_valid), .con_ready(a_con_ready), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_x(a_out_x), .out_y(a_out_y), .out_ch(a_out_ch),
    .ctrl_kds_le(a_kds_le), .ctrl_kds_ch(a_kds_ch), .ctrl_kds_word(a_kds_word),
    .ctrl_kds_cycle_en(a_kds_cycle_en), .ctrl_ids_le_sel(a_ids_le_sel),
    .ctrl_ids_shift(a_ids_shift), .ctrl_ods_sel(a_ods_sel), .ctrl_ods_shift(a_ods_shift),
`ifdef CONV_CTRL_PERF_CNT_EN
    .stall_cycles(a_stall),
`endif
    .driving_cons(a_driving)
  );

  conv_ctrl_fsm_param #(
    .FEATURE_MAP_WIDTH(BW), .FEATURE_MAP_HEIGHT(BH), .OUTPUT_NB_CHANNELS(BNB)
  ) u_dut_b (
    .clk(clk), .arst_n_in(b_rst_n), .start(b_start), .running(b_running), .done(b_done),
    .con_valid(b_con_valid), .con_ready(b_con_ready), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_x(b_out_x), .out_y(b_out_y), .out_ch(b_out_ch),
    .ctrl_kds_le(b_kds_le), .ctrl_kds_ch(b_kds_ch), .ctrl_kds_word(b_kds_word),
    .ctrl_kds_cycle_en(b_kds_cycle_en), .ctrl_ids_le_sel(b_ids_le_sel),
    .ctrl_ids_shift(b_ids_shift), .ctrl_ods_sel(b_ods_sel), .ctrl_ods_shift(b_ods_shift),
`ifdef CONV_CTRL_PERF_CNT_EN
    .stall_cycles(b_stall),
`endif
    .driving_cons(b_driving)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] a_all();
    return 128'({a_running, a_done, a_con_ready, a_out_valid, a_out_x, a_out_y, a_out_ch,
                 a_kds_le, a_kds_ch, a_kds_word, a_kds_cycle_en, a_ids_le_sel, a_ids_shift,
                 a_ods_sel, a_ods_shift, a_driving});
  endfunction

  function automatic logic [127:0] b_all();
    return 128'({b_running, b_done, b_con_ready, b_out_valid, b_out_x, b_out_y, b_out_ch,
                 b_kds_le, b_kds_ch, b_kds_word, b_kds_cycle_en, b_ids_le_sel, b_ids_shift,
                 b_ods_sel, b_ods_shift, b_driving});
  endfunction

  task automatic step_a(input logic st, input logic cv, input logic ory);
    @(negedge clk);
    a_start     = st;
    a_con_valid = cv;
    a_out_ready = ory;
    #1;
  endtask

  // Model state for instance B
  logic [47:0] exp_q[$];
  logic [47:0] held_xyc;
  logic        held;
  logic        done_seen;
  int          kcnt;

  task automatic step_b(input logic st);
    logic [47:0] xyc;
    @(negedge clk);
    b_start     = st;
    b_con_valid = 1'($urandom_range(0, 1));
    b_out_ready = 1'($urandom_range(0, 1));
    #1;
    if (b_kds_le || b_ids_le_sel != 8'd0)
      chk("b_strobe_needs_hs", 128'({b_con_valid, b_con_ready}), 128'(2'b11));
    if (b_kds_le) begin
      chk("b_kds_idx", 128'({b_kds_ch, b_kds_word}),
          128'({8'((kcnt / 12) % 6), 8'(kcnt % 12)}));
      kcnt++;
    end
    xyc = {b_out_x, b_out_y, b_out_ch};
    if (b_out_valid) begin
      chk("b_ch_in_range", 128'(b_out_ch < 16'(BNB)), 128'(1));
      if (held) chk("b_hold_coords", 128'(xyc), 128'(held_xyc));
      chk("b_ods_shift_on_accept", 128'(b_ods_shift), 128'(b_out_ready));
      if (b_out_ready) begin
        if (exp_q.size() == 0) chk("b_extra_beat", 128'(xyc), 128'(0));
        else chk("b_beat", 128'(xyc), 128'(exp_q.pop_front()));
      end
      held     = !b_out_ready;
      held_xyc = xyc;
    end else begin
      held = 1'b0;
    end
    if (b_done) begin
      chk("b_done_after_last", 128'(exp_q.size()), 128'(0));
      done_seen = 1'b1;
    end
  endtask

  task automatic run_b_layer(input int budget);
    int groups;
    exp_q.delete();
    for (int cb = 0; cb < BNB; cb += 6)
      for (int y = 0; y < BH; y++)
        for (int x = 0; x < BW; x++)
          for (int i = 0; i < 2; i++)
            if (cb + 3 * i < BNB) exp_q.push_back({16'(x), 16'(y), 16'(cb + 3 * i)});
    groups    = (BNB + 5) / 6;
    kcnt      = 0;
    held      = 1'b0;
    done_seen = 1'b0;
    chk("b_model_beats", 128'(exp_q.size()), 128'(BW * BH * 3));
    step_b(1'b1);
    for (int c = 0; c < budget && !done_seen; c++) step_b(1'b0);
    chk("b_done_seen", 128'(done_seen), 128'(1));
    chk("b_beats_left", 128'(exp_q.size()), 128'(0));
    chk("b_kds_total", 128'(kcnt), 128'(groups * 72));
    step_b(1'b0);
    chk("b_idle_after_done", 128'({b_running, b_done}), 128'(0));
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_start = 1'b0; a_con_valid = 1'b0; a_out_ready = 1'b0;
    b_start = 1'b0; b_con_valid = 1'b0; b_out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("a_reset_outputs", a_all(), 128'(0));
    chk("b_reset_outputs", b_all(), 128'(0));
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    chk("a_idle_outputs", a_all(), 128'(0));

    // Default configuration, directed sequence
    step_a(1'b1, 1'b1, 1'b1);
    chk("a_idle_on_start", 128'(a_running), 128'(0));
    for (int k = 0; k < 72; k++) begin
      step_a(1'b0, 1'b1, 1'b1);
      chk("a_load_k", 128'({a_running, a_con_ready, a_kds_le, a_kds_ch, a_kds_word}),
          128'({1'b1, 1'b1, 1'b1, 8'(k / 12), 8'(k % 12)}));
    end
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 4; w++) begin
        step_a(1'b0, 1'b1, 1'b1);
        chk("a_load_i", 128'({a_kds_le, a_con_ready, a_ids_le_sel, a_ids_shift}),
            128'({1'b0, 1'b1, 8'(w + 1), 1'b0}));
      end
      step_a(1'b0, 1'b1, 1'b1);
      chk("a_shift_i", 128'({a_con_ready, a_ids_le_sel, a_ids_shift}), 128'({1'b0, 8'd0, 1'b1}));
    end
    for (int b = 0; b < 6; b++) begin
      step_a(1'b0, 1'b1, 1'b1);
      chk("a_compute", 128'({a_kds_cycle_en, a_ods_sel, a_ods_shift, a_ids_le_sel, a_ids_shift}),
          128'({1'b1, 2'(b % 3), (b == 0 || b == 3 || b == 4), 8'(b < 4 ? b + 1 : 0), b == 5}));
    end
    step_a(1'b0, 1'b1, 1'b0);
    chk("a_wait", a_all(), 128'(1) << 127 >> 127 << 82);
    for (int s = 0; s < 7; s++) begin
      step_a(1'b0, 1'b1, 1'b0);
      chk("a_out_stall", 128'({a_out_valid, a_driving, a_out_x, a_out_y, a_out_ch, a_ods_shift,
                               a_kds_le, a_ids_le_sel}),
          128'({1'b1, 1'b1, 48'd0, 1'b0, 1'b0, 8'd0}));
    end
    step_a(1'b0, 1'b1, 1'b1);
    chk("a_beat0", 128'({a_out_valid, a_out_x, a_out_y, a_out_ch, a_ods_shift}),
        128'({1'b1, 16'd0, 16'd0, 16'd0, 1'b1}));
`ifdef CONV_CTRL_PERF_CNT_EN
    chk("a_stall_cycles", 128'(a_stall), 128'(7));
`endif
    step_a(1'b0, 1'b1, 1'b1);
    chk("a_beat1", 128'({a_out_valid, a_out_x, a_out_y, a_out_ch, a_ods_shift}),
        128'({1'b1, 16'd0, 16'd0, 16'd3, 1'b1}));
    step_a(1'b0, 1'b1, 1'b1);
    chk("a_next_pixel", 128'({a_out_valid, a_kds_cycle_en, a_ids_le_sel, a_ods_shift}),
        128'({1'b0, 1'b1, 8'd1, 1'b1}));
    step_a(1'b1, 1'b1, 1'b1);
    chk("a_start_ignored", 128'({a_running, a_kds_le, a_ids_le_sel}), 128'({1'b1, 1'b0, 8'd2}));

    // Small layer, random handshakes, two full runs around a mid-compute reset
    run_b_layer(6000);
    step_b(1'b1);
    for (int c = 0; c < 3000 && !b_kds_cycle_en; c++) step_b(1'b0);
    chk("b_reached_compute", 128'(b_kds_cycle_en), 128'(1));
    b_rst_n = 1'b0;
    #1;
    chk("b_async_reset", b_all(), 128'(0));
    @(negedge clk);
    #1;
    chk("b_held_in_reset", b_all(), 128'(0));
    b_rst_n = 1'b1;
    run_b_layer(6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
